breakbeam_column_tracker: RTL and testbench
===========================================

Name: breakbeam_column_tracker

Overview:
- Downstream of the break-beam debouncer; consumes its clean, synchronized beam signal.
- One beam-break event per revolution of the spinning LED arm.
- Measures the revolution period in clk cycles and divides each revolution into 2^COL_LOG2 equal angular columns.
- Emits column index, per-column tick and revolution tick to the POV frame/column fetch logic.

Parameters:
- COL_LOG2, 8: log2 of columns per revolution.
- PERIOD_W, 32: width of period counter and period output.
- MIN_PERIOD, 4096: triggers arriving fewer cycles than this after the last accepted trigger are glitches and ignored; must be >= 2^COL_LOG2.
- MAX_PERIOD, 100000000: cycles without an accepted trigger before declaring the rotor stopped.
- TRIG_ACTIVE_LOW, 1: 1 = trigger on falling edge of beam_in (beam broken drives low); 0 = rising edge.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- beam_in, input, 1: debounced, synchronized beam level.
- col_idx, output, COL_LOG2: current angular column.
- col_valid, output, 1: col_idx meaningful (state RUN).
- col_tick, output, 1: one-cycle pulse when col_idx takes a new value, including column 0 at a trigger.
- rev_tick, output, 1: one-cycle pulse per accepted trigger while in SYNC or RUN.
- period_cycles, output, PERIOD_W: last accepted (or filtered) revolution period.

Behaviour:
- Reset (synchronous, active-high): state IDLE; col_idx 0, col_valid 0, col_tick 0, rev_tick 0, period_cycles 0; internal counters 0; edge register loads the inactive level.
- Edge detect: beam_prev registered each cycle. trig = the active edge between beam_prev and beam_in. Latency from the beam_in transition to rev_tick/col_tick is 1 cycle.
- cnt: counts cycles since the last accepted trigger, saturating at MAX_PERIOD.
- Accepted trigger: trig && (state==IDLE || cnt+1 >= MIN_PERIOD). Rejected triggers change nothing.
- IDLE: accepted trigger -> SYNC, cnt <= 0. No ticks.
- SYNC: accepted trigger -> RUN.
  - period_cycles <= cnt+1; step <= max(1, (cnt+1) >> COL_LOG2).
  - col_idx <= 0, col_valid <= 1, col_tick and rev_tick pulse, sub <= 0, cnt <= 0.
- RUN, column advance: sub counts 0..step-1. When sub==step-1 and col_idx < 2^COL_LOG2-1: col_idx++, col_tick pulses, sub <= 0.
- RUN, saturation: at the last column, col_idx holds and col_tick is suppressed until the next trigger (rotor slowed). col_idx never wraps without a trigger.
- RUN, accepted trigger: same actions as SYNC->RUN. Step always uses the most recent period, i.e. the prediction for the coming revolution.
- Timeout: cnt+1 >= MAX_PERIOD in SYNC or RUN -> IDLE; col_valid 0, col_idx 0, no ticks. period_cycles holds its last value.
- Trigger and timeout in the same cycle: the trigger wins.
- Reset asserted mid-operation: immediate return to the reset values on that clock edge.
- Arithmetic: cnt+1 computed at PERIOD_W+1 bits. The shift for step is unsigned and truncating.

Optional Feature:
- Macro: BREAKBEAM_PERIOD_AVG_EN.
- Defined: on RUN->RUN accepted triggers, period_cycles <= (period_cycles + cnt + 1) >> 1 (PERIOD_W+1-bit sum), and step derives from the averaged value. SYNC->RUN loads the raw value.
- Undefined: raw period is used every revolution.

Decomposition:
- Shared package breakbeam_pkg: state enum {IDLE, SYNC, RUN}; default constants for COL_LOG2, PERIOD_W, MIN_PERIOD, MAX_PERIOD.
- One sub-module, pov_column_stepper: inputs step, restart and enable; owns sub and col_idx and the saturation logic; outputs col_idx and col_tick.
- Edge detect, period measurement and FSM stay in the top module.

Test Plan (COL_LOG2=4, MIN_PERIOD=32, MAX_PERIOD=4096, TRIG_ACTIVE_LOW=1):
- Steady rotation: falling edges every 160 cycles.
  - After the 2nd edge: period_cycles=160, col_valid=1, rev_tick each edge.
  - col_tick every 10 cycles; col_idx 0..15, returning to 0 at each edge.
- Glitch: extra falling edge 10 cycles after an accepted trigger -> no rev_tick, col_idx/period unchanged, column timing undisturbed.
- Slowdown: period 160, then next edge after 200 cycles.
  - col_idx holds at 15 with no col_tick from cycle 160 to 200.
  - Then period_cycles=200, step=12, col_idx=0.
- Timeout: in RUN, no edge for 4096 cycles -> col_valid=0, state IDLE. Next edge -> SYNC only; edge after that -> RUN.
- Reset mid-RUN at col_idx=7 -> next cycle all outputs 0; a subsequent single edge gives no rev_tick.
- With BREAKBEAM_PERIOD_AVG_EN: periods 160 then 200 -> period_cycles=180, step=11.

Source files
------------

// File: rtl/breakbeam_pkg.sv
// Shared types and default sizing for the break-beam column tracker.
package breakbeam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } bb_state_e;

  localparam int DEF_COL_LOG2   = 8;
  localparam int DEF_PERIOD_W   = 32;
  localparam int DEF_MIN_PERIOD = 4096;
  localparam int DEF_MAX_PERIOD = 100000000;

endpackage

// File: rtl/pov_column_stepper.sv
// Divides one revolution into equal columns: advances col_idx every `step`
// cycles after a restart and parks on the last column until the next restart.
module pov_column_stepper
  import breakbeam_pkg::*;
#(
  parameter int COL_LOG2 = DEF_COL_LOG2,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] step,
  input  logic                restart,
  input  logic                enable,
  output logic [COL_LOG2-1:0] col_idx,
  output logic                col_tick
);

  localparam logic [PERIOD_W-1:0] SUB_ONE  = 1;
  localparam logic [COL_LOG2-1:0] COL_ONE  = 1;
  localparam logic [COL_LOG2-1:0] COL_LAST = '1;

  logic [PERIOD_W-1:0] sub_q, sub_d;
  logic [COL_LOG2-1:0] col_q, col_d;
  logic                tick_q, tick_d;

  always_comb begin
    sub_d  = sub_q;
    col_d  = col_q;
    tick_d = 1'b0;
    if (restart) begin
      sub_d  = '0;
      col_d  = '0;
      tick_d = 1'b1;
    end else if (!enable) begin
      sub_d = '0;
      col_d = '0;
    end else if (sub_q == step - SUB_ONE) begin
      // At the last column sub parks at step-1 so col_idx never wraps on its own.
      if (col_q != COL_LAST) begin
        col_d  = col_q + COL_ONE;
        sub_d  = '0;
        tick_d = 1'b1;
      end
    end else begin
      sub_d = sub_q + SUB_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q  <= '0;
      col_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      sub_q  <= sub_d;
      col_q  <= col_d;
      tick_q <= tick_d;
    end
  end

  assign col_idx  = col_q;
  assign col_tick = tick_q;

endmodule

// File: rtl/breakbeam_column_tracker.sv
// Measures rotor period from beam-break edges and drives POV column timing.
// Optional macro BREAKBEAM_PERIOD_AVG_EN averages successive periods while running.
module breakbeam_column_tracker
  import breakbeam_pkg::*;
#(
  parameter int COL_LOG2        = DEF_COL_LOG2,
  parameter int PERIOD_W        = DEF_PERIOD_W,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD      = DEF_MAX_PERIOD,
  parameter int TRIG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beam_in,
  output logic [COL_LOG2-1:0] col_idx,
  output logic                col_valid,
  output logic                col_tick,
  output logic                rev_tick,
  output logic [PERIOD_W-1:0] period_cycles
);

  localparam logic [PERIOD_W:0]   CNT_ONE   = 1;
  localparam logic [PERIOD_W-1:0] STEP_ONE  = 1;
  localparam logic [PERIOD_W:0]   MIN_C     = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   MAX_C     = (PERIOD_W+1)'(MAX_PERIOD);
  localparam logic                BEAM_IDLE = (TRIG_ACTIVE_LOW != 0);

  bb_state_e           state_q, state_d;
  logic                beam_prev_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] step_q, step_d;
  logic                rev_q, rev_d;
  logic [PERIOD_W:0]   cnt_inc;
  logic [PERIOD_W-1:0] new_period;
  logic                trig, accept, timeout, restart, enable;

  function automatic logic [PERIOD_W-1:0] step_of(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] s;
    s = p >> COL_LOG2;
    return (s == '0) ? STEP_ONE : s;
  endfunction

  assign trig    = BEAM_IDLE ? (beam_prev_q & ~beam_in) : (~beam_prev_q & beam_in);
  assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;
  assign accept  = trig && ((state_q == ST_IDLE) || (cnt_inc >= MIN_C));
  assign timeout = (state_q != ST_IDLE) && (cnt_inc >= MAX_C);

`ifdef BREAKBEAM_PERIOD_AVG_EN
  // Only RUN->RUN revolutions blend with the previous estimate.
  assign new_period = (state_q == ST_RUN) ?
                      PERIOD_W'(({1'b0, period_q} + cnt_inc) >> 1) :
                      cnt_inc[PERIOD_W-1:0];
`else
  assign new_period = cnt_inc[PERIOD_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_inc >= MAX_C) ? MAX_C[PERIOD_W-1:0] : cnt_inc[PERIOD_W-1:0];
    period_d = period_q;
    step_d   = step_q;
    rev_d    = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end
      end
      ST_SYNC, ST_RUN: begin
        // A trigger landing on the timeout cycle still counts as a revolution.
        if (accept) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          period_d = new_period;
          step_d   = step_of(new_period);
          rev_d    = 1'b1;
          restart  = 1'b1;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enable = (state_q == ST_RUN) && !timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beam_prev_q <= BEAM_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      step_q      <= '0;
      rev_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beam_prev_q <= beam_in;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      step_q      <= step_d;
      rev_q       <= rev_d;
    end
  end

  pov_column_stepper #(
    .COL_LOG2(COL_LOG2),
    .PERIOD_W(PERIOD_W)
  ) u_stepper (
    .clk     (clk),
    .reset   (reset),
    .step    (step_q),
    .restart (restart),
    .enable  (enable),
    .col_idx (col_idx),
    .col_tick(col_tick)
  );

  assign col_valid     = (state_q == ST_RUN);
  assign rev_tick      = rev_q;
  assign period_cycles = period_q;

endmodule

// File: tb/tb_breakbeam_column_tracker.sv
// Bench for breakbeam_column_tracker: edge table plus hand sequences, per-cycle scoreboard.
module tb_breakbeam_column_tracker;

  localparam int COLS   = 4;
  localparam int PW     = 32;
  localparam int MINP   = 32;
  localparam int MAXP   = 4096;
  localparam int LASTC  = 15;

  logic          clk;
  logic          reset;
  logic          beam_in;
  logic [COLS-1:0] col_idx;
  logic          col_valid;
  logic          col_tick;
  logic          rev_tick;
  logic [PW-1:0] period_cycles;

  breakbeam_column_tracker #(
    .COL_LOG2       (COLS),
    .PERIOD_W       (PW),
    .MIN_PERIOD     (MINP),
    .MAX_PERIOD     (MAXP),
    .TRIG_ACTIVE_LOW(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .beam_in      (beam_in),
    .col_idx      (col_idx),
    .col_valid    (col_valid),
    .col_tick     (col_tick),
    .rev_tick     (rev_tick),
    .period_cycles(period_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int col;
    bit ctick;
    bit rtick;
    bit valid;
    int per;
  } exp_t;

  typedef struct {
    int gap;
    bit rev;
    int per_raw;
    int per_avg;
  } edge_t;

  exp_t  sb[$];
  edge_t tbl[8];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int lowcnt = 0;

  // Reference model: column derived arithmetically from time since the last revolution.
  int m_state = 0;
  int m_last  = 0;
  int m_step  = 1;
  int m_period = 0;
  bit m_prev  = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model(input logic b, input logic r, output exp_t e);
    int  el;
    int  p;
    bit  trig;
    bit  acc;
    cyc++;
    el = cyc - m_last;
    e = '{col: 0, ctick: 1'b0, rtick: 1'b0, valid: 1'b0, per: 0};
    if (r) begin
      m_state = 0; m_last = cyc; m_period = 0; m_step = 1; m_prev = 1'b1;
    end else begin
      trig = m_prev && !b;
      m_prev = b;
      acc = trig && (m_state == 0 || el >= MINP);
      if (acc && m_state == 0) begin
        m_state = 1; m_last = cyc;
      end else if (acc) begin
        p = el;
`ifdef BREAKBEAM_PERIOD_AVG_EN
        if (m_state == 2) p = (m_period + el) / 2;
`endif
        m_period = p;
        m_step = ((p >> COLS) < 1) ? 1 : (p >> COLS);
        m_state = 2; m_last = cyc;
        e.ctick = 1'b1; e.rtick = 1'b1; e.valid = 1'b1;
      end else if (m_state != 0 && el >= MAXP) begin
        m_state = 0;
      end else if (m_state == 2) begin
        e.valid = 1'b1;
        e.col   = (el / m_step > LASTC) ? LASTC : el / m_step;
        e.ctick = (el % m_step == 0) && (el / m_step <= LASTC);
      end
    end
    e.per = m_period;
  endtask

  task automatic tick(input logic b, input logic r);
    exp_t e;
    beam_in = b;
    reset   = r;
    model(b, r, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("col_idx",   32'(col_idx),       32'(e.col));
    check("col_tick",  32'(col_tick),      32'(e.ctick));
    check("rev_tick",  32'(rev_tick),      32'(e.rtick));
    check("col_valid", 32'(col_valid),     32'(e.valid));
    check("period",    period_cycles,      32'(e.per));
  endtask

  task automatic hold_cycle();
    if (lowcnt > 0) begin
      lowcnt--;
      tick(1'b0, 1'b0);
    end else begin
      tick(1'b1, 1'b0);
    end
  endtask

  // Falling edge `gap` cycles after the previous one; beam stays low 3 cycles.
  task automatic edge_after(input int gap);
    for (int i = 1; i < gap; i++) hold_cycle();
    tick(1'b0, 1'b0);
    lowcnt = 2;
  endtask

  initial begin
    tbl[0] = '{gap: 20,   rev: 1'b0, per_raw: 0,    per_avg: 0};
    tbl[1] = '{gap: 160,  rev: 1'b1, per_raw: 160,  per_avg: 160};
    tbl[2] = '{gap: 160,  rev: 1'b1, per_raw: 160,  per_avg: 160};
    tbl[3] = '{gap: 10,   rev: 1'b0, per_raw: 160,  per_avg: 160};
    tbl[4] = '{gap: 150,  rev: 1'b1, per_raw: 160,  per_avg: 160};
    tbl[5] = '{gap: 200,  rev: 1'b1, per_raw: 200,  per_avg: 180};
    tbl[6] = '{gap: 160,  rev: 1'b1, per_raw: 160,  per_avg: 170};
    tbl[7] = '{gap: 4096, rev: 1'b1, per_raw: 4096, per_avg: 2133};

    beam_in = 1'b1;
    reset   = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("reset_valid",  32'(col_valid), 32'd0);
    check("reset_col",    32'(col_idx),   32'd0);
    check("reset_period", period_cycles,  32'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      edge_after(tbl[i].gap);
      check("edge_rev", 32'(rev_tick), 32'(tbl[i].rev));
`ifdef BREAKBEAM_PERIOD_AVG_EN
      check("edge_period", period_cycles, 32'(tbl[i].per_avg));
`else
      check("edge_period", period_cycles, 32'(tbl[i].per_raw));
`endif
    end

    // Rotor stops: valid right up to the last cycle, dropped exactly at the timeout.
    for (int i = 0; i < 4095; i++) hold_cycle();
    check("pre_timeout_valid", 32'(col_valid), 32'd1);
    check("pre_timeout_col",   32'(col_idx),   32'd15);
    hold_cycle();
    check("timeout_valid", 32'(col_valid), 32'd0);
    check("timeout_col",   32'(col_idx),   32'd0);
    edge_after(50);
    check("resync_rev",   32'(rev_tick),  32'd0);
    check("resync_valid", 32'(col_valid), 32'd0);
    edge_after(160);
    check("rerun_rev",    32'(rev_tick),  32'd1);
    check("rerun_valid",  32'(col_valid), 32'd1);
    check("rerun_period", period_cycles,  32'd160);

    // Reset in the middle of a revolution, then a lone edge only resynchronises.
    for (int i = 0; i < 70; i++) hold_cycle();
    check("mid_col7", 32'(col_idx), 32'd7);
    tick(1'b1, 1'b1);
    check("rst_col",    32'(col_idx),   32'd0);
    check("rst_valid",  32'(col_valid), 32'd0);
    check("rst_ctick",  32'(col_tick),  32'd0);
    check("rst_rtick",  32'(rev_tick),  32'd0);
    check("rst_period", period_cycles,  32'd0);
    lowcnt = 0;
    tick(1'b1, 1'b0);
    edge_after(20);
    check("post_rst_rev", 32'(rev_tick), 32'd0);
    for (int i = 0; i < 10; i++) hold_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
